senha_controle: RTL and testbench
=================================

Name: senha_controle

Overview:
- Session controller that sequences the 4-digit password FSM (MEF_Senha family).
- Opens and closes password sessions by driving EM_SENHA, and generates the inactivity timeout TEMP_INATI.
- Counts consecutive wrong attempts and enforces a lockout after MAX_ERROS failures.
- Times the door-open (ABRE) window after a correct code; sits between the front-panel buttons and the password FSM.

Parameters:
- TIMEOUT, 50: cycles without an EN strobe, while the FSM is in a digit state, before TEMP_INATI is raised.
- MAX_ERROS, 3: consecutive wrong attempts that trigger lockout (legal range 1..15).
- OPEN_CYCLES, 20: cycles ABRE stays high after CERTO.
- LOCK_CYCLES, 100: cycles of lockout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- INICIA  in  1  start-session pulse (debounced, one cycle)
- CANCELA  in  1  abort-session pulse
- EN  in  1  digit-entered strobe (same signal the FSM receives)
- CERTO  in  1  FSM is in state OK
- ERRO  in  1  FSM is in state ER (one-cycle pulse)
- INATIVO  in  1  FSM is in state IN
- S_INATI  in  1  FSM is in a digit state S1..S4
- EM_SENHA  out  1  session enable to the FSM
- TEMP_INATI  out  1  inactivity timeout to the FSM
- ABRE  out  1  door-open command
- BLOQUEADO  out  1  lockout active
- N_ERROS  out  4  consecutive-error count

Behaviour:
- All outputs are registered. On rst, asynchronously: state=IDLE, all outputs 0, all counters 0.
- States: IDLE, SESSAO, ABERTO, BLOQ.
- IDLE:
  - EM_SENHA=0.
  - INICIA -> SESSAO; EM_SENHA=1 from the next cycle.
  - CANCELA is ignored.
- SESSAO: EM_SENHA=1. Events are checked in this priority order:
  1. CANCELA -> IDLE, EM_SENHA=0 next cycle, N_ERROS kept.
  2. CERTO -> ABERTO, N_ERROS cleared.
  3. INATIVO -> IDLE, EM_SENHA=0 next cycle, N_ERROS kept.
  4. ERRO:
     - N_ERROS incremented.
     - If the new value equals MAX_ERROS -> BLOQ, EM_SENHA=0 next cycle.
     - Otherwise stay in SESSAO; the FSM restarts by itself via ER->S0->S1.
  - INICIA is ignored while in SESSAO.
- Inactivity timer (SESSAO only):
  - Cleared when S_INATI=0, when EN=1, on ERRO, and on leaving SESSAO.
  - Otherwise increments, saturating at TIMEOUT.
  - TEMP_INATI=1 while the timer equals TIMEOUT, i.e. first asserted TIMEOUT cycles after the last clearing cycle.
  - TEMP_INATI is held until INATIVO is seen and is forced to 0 outside SESSAO.
  - EN in the same cycle as saturation clears the timer; EN wins.
- ABERTO:
  - EM_SENHA=1, so the FSM holds OK.
  - ABRE=1 for exactly OPEN_CYCLES cycles, starting the cycle after CERTO is sampled.
  - Then -> IDLE, with ABRE=0 and EM_SENHA=0 on the same edge.
  - CANCELA ends the window early, same way. INICIA is ignored.
- BLOQ:
  - EM_SENHA=0, BLOQUEADO=1 for exactly LOCK_CYCLES cycles.
  - INICIA and CANCELA are ignored.
  - At expiry -> IDLE, BLOQUEADO=0, N_ERROS cleared.
- Simultaneous events:
  - CERTO and ERRO together cannot occur legally; if they do, CERTO wins.
  - INICIA and CANCELA together in IDLE: INICIA wins.
- Width rules:
  - Counters are sized with $clog2(param+1).
  - N_ERROS never exceeds MAX_ERROS.
  - Timers never wrap.
- Reset asserted mid-session or mid-lockout returns to IDLE immediately: EM_SENHA, ABRE and BLOQUEADO drop asynchronously.

Test Plan:
- INICIA pulse, four correct digits via the FSM model -> EM_SENHA=1 one cycle after INICIA; CERTO -> ABRE high exactly 20 cycles, then EM_SENHA=0 and state IDLE; N_ERROS=0.
- Three wrong attempts, each producing an ERRO pulse -> N_ERROS=1, 2, then 3; BLOQUEADO=1 for exactly 100 cycles with EM_SENHA=0; INICIA during lockout ignored; afterwards N_ERROS=0.
- Session started, FSM in S2, no EN for 50 cycles -> TEMP_INATI rises on cycle 50; FSM raises INATIVO -> EM_SENHA=0 and TEMP_INATI=0 next cycle.
- EN strobe at cycle 49 of inactivity -> timer cleared, TEMP_INATI stays 0; timeout recurs 50 cycles after the strobe.
- Two errors, then a correct code -> N_ERROS goes 2 -> 0 on CERTO, no lockout; a later single error gives N_ERROS=1.
- Reset asserted mid-lockout at cycle 40, and separately mid-ABRE at cycle 5 -> all outputs 0 without waiting for a clock edge; INICIA after release starts a fresh session.

Source files
------------

// File: rtl/senha_controle.sv
// senha_controle: session controller for the 4-digit password FSM.
// Opens and closes password sessions (EM_SENHA), generates the inactivity
// timeout (TEMP_INATI), counts consecutive wrong attempts with lockout, and
// times the door-open window after a correct code.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   INICIA     in   start-session pulse
//   CANCELA    in   abort-session pulse
//   EN         in   digit-entered strobe
//   CERTO      in   FSM in state OK
//   ERRO       in   FSM in state ER (one-cycle pulse)
//   INATIVO    in   FSM in state IN
//   S_INATI    in   FSM in a digit state S1..S4
//   EM_SENHA   out  session enable to the FSM
//   TEMP_INATI out  inactivity timeout to the FSM
//   ABRE       out  door-open command
//   BLOQUEADO  out  lockout active
//   N_ERROS    out  consecutive-error count
module senha_controle #(
    parameter int unsigned TIMEOUT     = 50,
    parameter int unsigned MAX_ERROS   = 3,
    parameter int unsigned OPEN_CYCLES = 20,
    parameter int unsigned LOCK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       INICIA,
    input  logic       CANCELA,
    input  logic       EN,
    input  logic       CERTO,
    input  logic       ERRO,
    input  logic       INATIVO,
    input  logic       S_INATI,
    output logic       EM_SENHA,
    output logic       TEMP_INATI,
    output logic       ABRE,
    output logic       BLOQUEADO,
    output logic [3:0] N_ERROS
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam int unsigned EW       = $clog2(MAX_ERROS + 1);
    localparam int unsigned HOLD_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [EW-1:0] EMAX = EW'(MAX_ERROS);
    localparam logic [HW-1:0] OMAX = HW'(OPEN_CYCLES);
    localparam logic [HW-1:0] LMAX = HW'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SESSAO,
        ST_ABERTO,
        ST_BLOQ
    } state_t;

    state_t        r_state, w_state_n;
    logic          r_em, w_em_n;
    logic          r_temp, w_temp_n;
    logic          r_abre, w_abre_n;
    logic          r_bloq, w_bloq_n;
    logic [EW-1:0] r_nerros, w_nerros_n;
    logic [EW-1:0] w_nerros_inc;
    logic [TW-1:0] r_tmr, w_tmr_n;
    // Shared cycle counter for the ABRE window and the lockout period;
    // the two never run at the same time.
    logic [HW-1:0] r_hold, w_hold_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_em     <= 1'b0;
            r_temp   <= 1'b0;
            r_abre   <= 1'b0;
            r_bloq   <= 1'b0;
            r_nerros <= '0;
            r_tmr    <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_em     <= w_em_n;
            r_temp   <= w_temp_n;
            r_abre   <= w_abre_n;
            r_bloq   <= w_bloq_n;
            r_nerros <= w_nerros_n;
            r_tmr    <= w_tmr_n;
            r_hold   <= w_hold_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_em_n       = r_em;
        w_abre_n     = r_abre;
        w_bloq_n     = r_bloq;
        w_nerros_n   = r_nerros;
        w_hold_n     = r_hold;
        // Timer and timeout flag fall to zero unless the session keeps
        // counting undisturbed; this covers every clearing condition.
        w_tmr_n      = '0;
        w_temp_n     = 1'b0;
        w_nerros_inc = r_nerros + 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                w_em_n   = 1'b0;
                w_abre_n = 1'b0;
                w_bloq_n = 1'b0;
                w_hold_n = '0;
                if (INICIA) begin
                    w_state_n = ST_SESSAO;
                    w_em_n    = 1'b1;
                end
            end

            ST_SESSAO: begin
                w_em_n = 1'b1;
                if (CANCELA) begin
                    w_state_n = ST_IDLE;
                    w_em_n    = 1'b0;
                end else if (CERTO) begin
                    w_state_n  = ST_ABERTO;
                    w_nerros_n = '0;
                    w_abre_n   = 1'b1;
                    w_hold_n   = HW'(1);
                end else if (INATIVO) begin
                    w_state_n = ST_IDLE;
                    w_em_n    = 1'b0;
                end else if (ERRO) begin
                    w_nerros_n = w_nerros_inc;
                    if (w_nerros_inc == EMAX) begin
                        w_state_n = ST_BLOQ;
                        w_em_n    = 1'b0;
                        w_bloq_n  = 1'b1;
                        w_hold_n  = HW'(1);
                    end
                end else if (S_INATI && !EN) begin
                    w_tmr_n  = (r_tmr == TMAX) ? TMAX : r_tmr + 1'b1;
                    w_temp_n = (w_tmr_n == TMAX);
                end
            end

            ST_ABERTO: begin
                // r_hold counts ABRE-high cycles, starting at 1 on entry.
                if (CANCELA || r_hold == OMAX) begin
                    w_state_n = ST_IDLE;
                    w_em_n    = 1'b0;
                    w_abre_n  = 1'b0;
                    w_hold_n  = '0;
                end else begin
                    w_hold_n = r_hold + 1'b1;
                end
            end

            ST_BLOQ: begin
                w_em_n = 1'b0;
                if (r_hold == LMAX) begin
                    w_state_n  = ST_IDLE;
                    w_bloq_n   = 1'b0;
                    w_nerros_n = '0;
                    w_hold_n   = '0;
                end else begin
                    w_hold_n = r_hold + 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_em_n    = 1'b0;
                w_abre_n  = 1'b0;
                w_bloq_n  = 1'b0;
                w_hold_n  = '0;
            end
        endcase
    end

    assign EM_SENHA   = r_em;
    assign TEMP_INATI = r_temp;
    assign ABRE       = r_abre;
    assign BLOQUEADO  = r_bloq;
    assign N_ERROS    = 4'(r_nerros);

endmodule

// File: tb/tb_senha_controle.sv
// Self-checking bench for senha_controle: table-driven single-cycle vectors
// plus directed multi-cycle sequences (open window, lockout, inactivity
// timeout, error clearing, asynchronous reset).
module tb_senha_controle;

    logic       clk;
    logic       rst;
    logic       INICIA, CANCELA, EN, CERTO, ERRO, INATIVO, S_INATI;
    logic       EM_SENHA, TEMP_INATI, ABRE, BLOQUEADO;
    logic [3:0] N_ERROS;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    senha_controle #(
        .TIMEOUT    (50),
        .MAX_ERROS  (3),
        .OPEN_CYCLES(20),
        .LOCK_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .INICIA    (INICIA),
        .CANCELA   (CANCELA),
        .EN        (EN),
        .CERTO     (CERTO),
        .ERRO      (ERRO),
        .INATIVO   (INATIVO),
        .S_INATI   (S_INATI),
        .EM_SENHA  (EM_SENHA),
        .TEMP_INATI(TEMP_INATI),
        .ABRE      (ABRE),
        .BLOQUEADO (BLOQUEADO),
        .N_ERROS   (N_ERROS)
    );

    // Packed view: {EM_SENHA, TEMP_INATI, ABRE, BLOQUEADO, N_ERROS}
    assign obs = {EM_SENHA, TEMP_INATI, ABRE, BLOQUEADO, N_ERROS};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ini, can, en, cer, err, inat, sin;
        logic [7:0] exp;
    } vec_t;

    vec_t tv[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one rising edge, then settle just after it.
    task automatic step(input logic ini, input logic can, input logic en, input logic cer,
                        input logic err, input logic inat, input logic sin);
        INICIA  = ini;
        CANCELA = can;
        EN      = en;
        CERTO   = cer;
        ERRO    = err;
        INATIVO = inat;
        S_INATI = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input logic sin);
        step(0, 0, 0, 0, 0, 0, sin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int em_bad;

        tv[0]  = '{ini:0, can:1, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h00};
        tv[1]  = '{ini:1, can:1, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h80};
        tv[2]  = '{ini:1, can:0, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h80};
        tv[3]  = '{ini:0, can:0, en:0, cer:0, err:1, inat:0, sin:0, exp:8'h81};
        tv[4]  = '{ini:0, can:0, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h81};
        tv[5]  = '{ini:0, can:1, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h01};
        tv[6]  = '{ini:0, can:1, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h01};
        tv[7]  = '{ini:1, can:0, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h81};
        tv[8]  = '{ini:0, can:0, en:0, cer:0, err:1, inat:0, sin:0, exp:8'h82};
        tv[9]  = '{ini:0, can:0, en:0, cer:1, err:1, inat:0, sin:0, exp:8'hA0};
        tv[10] = '{ini:0, can:1, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h00};
        tv[11] = '{ini:1, can:0, en:0, cer:0, err:0, inat:0, sin:0, exp:8'h80};
        tv[12] = '{ini:0, can:0, en:0, cer:0, err:0, inat:1, sin:0, exp:8'h00};

        rst = 1'b1;
        INICIA = 0; CANCELA = 0; EN = 0; CERTO = 0; ERRO = 0; INATIVO = 0; S_INATI = 0;
        #2;
        check("reset_state", 32'(obs), 32'h00);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tv[i].ini, tv[i].can, tv[i].en, tv[i].cer, tv[i].err, tv[i].inat, tv[i].sin);
            check($sformatf("vec%0d", i), 32'(obs), 32'(tv[i].exp));
        end

        // Correct code: ABRE window of 20 cycles, then back to IDLE.
        step(1, 0, 0, 0, 0, 0, 0);
        check("open_session", 32'(obs), 32'h80);
        for (int d = 0; d < 4; d++) begin
            step(0, 0, 1, 0, 0, 0, 1);
            quiet(1);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        check("open_certo", 32'(obs), 32'hA0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!ABRE) break;
            cnt++;
            step(0, 0, 0, 1, 0, 0, 0);
        end
        check("open_len", 32'(cnt), 32'd20);
        check("open_end", 32'(obs), 32'h00);

        // Three errors -> lockout of 100 cycles, INICIA ignored inside.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("err1", 32'(obs), 32'h81);
        quiet(0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("err2", 32'(obs), 32'h82);
        quiet(0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("err3_lock", 32'(obs), 32'h13);
        cnt = 0;
        em_bad = 0;
        for (int k = 0; k < 150; k++) begin
            if (!BLOQUEADO) break;
            cnt++;
            if (EM_SENHA) em_bad++;
            step((k == 10) || (k == 99), (k == 20), 0, 0, 0, 0, 0);
        end
        check("lock_len", 32'(cnt), 32'd100);
        check("lock_em", 32'(em_bad), 32'd0);
        check("lock_end", 32'(obs), 32'h00);

        // Inactivity timeout 50 cycles after the last EN strobe.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 49; k++) quiet(1);
        check("tmo_49", 32'(obs), 32'h80);
        quiet(1);
        check("tmo_50", 32'(obs), 32'hC0);
        quiet(1);
        check("tmo_hold", 32'(obs), 32'hC0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("tmo_inativo", 32'(obs), 32'h00);

        // EN at cycle 49 restarts the timer.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 48; k++) quiet(1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("en49_clear", 32'(obs), 32'h80);
        for (int k = 0; k < 49; k++) quiet(1);
        check("en49_49", 32'(obs), 32'h80);
        quiet(1);
        check("en49_50", 32'(obs), 32'hC0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("en49_exit", 32'(obs), 32'h00);

        // Two errors then a correct code clears the count.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("two_err", 32'(obs), 32'h82);
        step(0, 0, 0, 1, 0, 0, 0);
        check("two_err_certo", 32'(obs), 32'hA0);
        step(0, 1, 0, 1, 0, 0, 0);
        check("abre_cancel", 32'(obs), 32'h00);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("later_err", 32'(obs), 32'h81);
        step(0, 1, 0, 0, 0, 0, 0);
        check("keep_err", 32'(obs), 32'h01);

        // Reset mid-lockout drops outputs without a clock edge.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("lock2", 32'(obs), 32'h13);
        for (int k = 0; k < 40; k++) quiet(0);
        check("lock2_mid", 32'(obs), 32'h13);
        #2 rst = 1'b1;
        #1 check("rst_lock", 32'(obs), 32'h00);
        #1 rst = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        check("fresh1", 32'(obs), 32'h80);

        // Reset mid-ABRE.
        step(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 0, 0);
        check("abre_mid", 32'(obs), 32'hA0);
        #2 rst = 1'b1;
        #1 check("rst_abre", 32'(obs), 32'h00);
        #1 rst = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        check("fresh2", 32'(obs), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
